aes_key_expander: RTL and testbench
===================================

Name: aes_key_expander

Overview:
- Iterative AES key-schedule engine upstream of the cipher-unit control FSM.
- Expands a 128/192/256-bit cipher key into the full round-key array, one 32-bit word per cycle, and raises KF when the schedule is complete.
- Serves the 128-bit round key selected by the controller's round counter R.
- Reverses the round order for decryption so the datapath always indexes by R.

Parameters:
- MAXW, 60, depth of the word array (4*(14+1)); sized for AES-256.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- CLR  in  1  synchronous active-low reset.
- START  in  1  one-cycle pulse: latch KEY/KL and begin expansion.
- KEY  in  256  cipher key, MSB-aligned: AES-128 uses [255:128], AES-192 uses [255:64], AES-256 uses [255:0].
- KL  in  2  key length: 0=128, 1=192, 2=256, 3=illegal.
- ENC_DEC  in  1  1=encrypt, 0=decrypt; selects round-key order.
- R  in  4  round index from the control unit.
- KF  out  1  round keys valid (key flag).
- BUSY  out  1  expansion in progress.
- KL_ERR  out  1  sticky: last START had KL=3.
- RK  out  128  round key {w[4k],w[4k+1],w[4k+2],w[4k+3]}.

Behaviour:
- Reset (CLR=0 at an edge): state IDLE; KF=0, BUSY=0, KL_ERR=0, RK=0.
  - Word-array contents are don't-care after reset.
  - Reset mid-expansion aborts immediately; KF stays 0.
- Key-length table:
  - KL=0: Nk=4, Nr=10, 44 words.
  - KL=1: Nk=6, Nr=12, 52 words.
  - KL=2: Nk=8, Nr=14, 60 words.
  - Nk and Nr are latched at START.
- FSM states: IDLE, EXPAND, DONE.
- IDLE/DONE with START=1 and KL≠3, at edge t0:
  - Write w[0..Nk-1] from KEY, most-significant word is w[0].
  - KF←0, BUSY←1, KL_ERR←0, i←Nk, j←0, rcon←8'h01; go to EXPAND.
- IDLE/DONE with START=1 and KL=3:
  - KL_ERR←1, KF←0; go to IDLE.
  - Existing array contents are not modified.
- EXPAND: each edge writes w[i]=w[i-Nk]^temp, where temp=w[i-1] by default, except:
  - j==0: temp=SubWord(RotWord(w[i-1]))^{rcon,24'h0}; after use, rcon←xtime(rcon), giving 01,02,04,08,10,20,40,80,1B,36.
  - Nk==8 and j==4: temp=SubWord(w[i-1]).
  - j counts 0..Nk-1 and wraps. Modulo and divide operators are not used.
- Final word: the edge that writes w[4Nr+3] also sets KF←1, BUSY←0 and moves to DONE.
  - KF rises at edge t0+40 (AES-128), t0+46 (AES-192), t0+52 (AES-256).
- START during EXPAND is ignored; KEY/KL changes during EXPAND are ignored.
- RK is registered, updated every edge, 1-cycle latency from R/ENC_DEC:
  - k = ENC_DEC ? R : Nr−R; RK←words 4k..4k+3.
  - R>Nr gives RK=0.
  - KF=0 gives RK=0.
- SubWord: four parallel S-box lookups, combinational, within the single cycle.
- All XOR is 32-bit bitwise. rcon is an 8-bit register; xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 0).

Decomposition:
- Package aes_ks_pkg:
  - kl_t enum {KL128, KL192, KL256, KLBAD}.
  - nk_of() and nr_of() functions.
  - ks_state_t enum.
  - SBOX constant array (256×8).
  - xtime() function.
- Sub-module aes_sbox: 8-bit combinational lookup from pkg SBOX, instantiated 4× for SubWord.

Test Plan:
- FIPS-197 A.1, KL=0, ENC_DEC=1, KEY[255:128]=2b7e151628aed2a6abf7158809cf4f3c, START pulse:
  - KF rises exactly 40 cycles after the START edge.
  - R=1 → RK=a0fafe1788542cb123a339392a6c7605.
  - R=10 → RK=d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 A.2, KL=1, KEY[255:64]=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - KF after 46 cycles; R=12 → RK=e98ba06f448c773c8ecc720401002202.
- FIPS-197 A.3, KL=2, KEY=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - KF after 52 cycles; R=14 → RK=fe4890d1e6188d0b046df344706c631e.
- Decrypt ordering, AES-128 key from A.1, ENC_DEC=0:
  - R=0 → RK=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - R=10 → RK=2b7e151628aed2a6abf7158809cf4f3c.
  - R=11 → RK=0.
- Reset mid-expansion: CLR=0 at cycle 20 of an AES-128 run → KF=0, BUSY=0, RK=0. A new START then completes normally in 40 cycles with correct keys.
- Illegal length: START with KL=3 → KL_ERR=1, KF=0, state IDLE.
  - A following legal START clears KL_ERR.
  - A START pulse during EXPAND has no effect on completion time or key values.

Source files
------------

// File: rtl/aes_ks_pkg.sv
// Shared types, constants and helpers for the AES key-schedule engine.
package aes_ks_pkg;

   typedef enum logic [1:0] {KL128 = 2'd0, KL192 = 2'd1, KL256 = 2'd2, KLBAD = 2'd3} kl_t;

   typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} ks_state_t;

   function automatic logic [3:0] nk_of(input kl_t k);
      case (k)
         KL192:   nk_of = 4'd6;
         KL256:   nk_of = 4'd8;
         default: nk_of = 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input kl_t k);
      case (k)
         KL192:   nr_of = 4'd12;
         KL256:   nr_of = 4'd14;
         default: nr_of = 4'd10;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_ks_sbox.sv
// Single combinational AES S-box lookup.
module aes_sbox
   import aes_ks_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   always_comb y = SBOX[a];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one word per cycle, round key served by R.
module aes_key_expander
   import aes_ks_pkg::*;
#(
   parameter int unsigned MAXW = 60
) (
   input  logic         CLK,
   input  logic         CLR,
   input  logic         START,
   input  logic [255:0] KEY,
   input  logic [1:0]   KL,
   input  logic         ENC_DEC,
   input  logic [3:0]   R,
   output logic         KF,
   output logic         BUSY,
   output logic         KL_ERR,
   output logic [127:0] RK
);

   ks_state_t   state, state_nxt;
   logic [31:0] w [0:MAXW-1];
   logic [5:0]  i;
   logic [3:0]  j;
   logic [7:0]  rcon;
   logic [3:0]  nk, nr;
   logic        go, bad, last;

   logic [31:0]  prev, sub_in, sub_out, temp;
   logic [5:0]   i_m1, i_mnk, last_idx;
   logic [3:0]   k;
   logic [127:0] rk_nxt;

   // ---------------- control FSM ----------------
   always_ff @(posedge CLK) begin
      if (!CLR) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      go        = 1'b0;
      bad       = 1'b0;
      last      = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (START) begin
               if (kl_t'(KL) == KLBAD) begin
                  bad       = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  go        = 1'b1;
                  state_nxt = S_EXPAND;
               end
            end
         end
         S_EXPAND: begin
            if (i == last_idx) begin
               last      = 1'b1;
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- word recurrence ----------------
   assign i_m1     = i - 6'd1;
   assign i_mnk    = i - {2'b00, nk};
   assign last_idx = {nr, 2'b11};
   assign prev     = w[i_m1];
   assign sub_in   = (j == 4'd0) ? {prev[23:0], prev[31:24]} : prev;

   for (genvar g = 0; g < 4; g++) begin : g_sub
      aes_sbox u_sbox (.a(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
   end

   always_comb begin
      temp = prev;
      if (j == 4'd0)
         temp = sub_out ^ {rcon, 24'h0};
      else if (nk == 4'd8 && j == 4'd4)
         temp = sub_out;
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         if (go) begin
            for (int unsigned n = 0; n < 8; n++)
               if (n < 32'(nk_of(kl_t'(KL))))
                  w[n] <= KEY[255 - 32*n -: 32];
         end else if (state == S_EXPAND) begin
            w[i] <= w[i_mnk] ^ temp;
         end
      end
   end

   // ---------------- round-key read ----------------
   // Decryption mirrors the round index so the datapath can always count R upward.
   assign k = ENC_DEC ? R : (nr - R);

   always_comb begin
      rk_nxt = '0;
      if (KF && R <= nr)
         rk_nxt = {w[{k, 2'b00}], w[{k, 2'b01}], w[{k, 2'b10}], w[{k, 2'b11}]};
   end

   // ---------------- status / counters ----------------
   always_ff @(posedge CLK) begin
      if (!CLR) begin
         KF     <= 1'b0;
         BUSY   <= 1'b0;
         KL_ERR <= 1'b0;
         RK     <= '0;
         i      <= '0;
         j      <= '0;
         rcon   <= 8'h01;
         nk     <= 4'd4;
         nr     <= 4'd10;
      end else begin
         RK <= rk_nxt;
         if (go) begin
            KF     <= 1'b0;
            BUSY   <= 1'b1;
            KL_ERR <= 1'b0;
            nk     <= nk_of(kl_t'(KL));
            nr     <= nr_of(kl_t'(KL));
            i      <= {2'b00, nk_of(kl_t'(KL))};
            j      <= '0;
            rcon   <= 8'h01;
         end
         if (bad) begin
            KL_ERR <= 1'b1;
            KF     <= 1'b0;
         end
         if (state == S_EXPAND) begin
            i <= i + 6'd1;
            j <= (j == nk - 4'd1) ? 4'd0 : j + 4'd1;
            if (j == 4'd0) rcon <= xtime(rcon);
            if (last) begin
               KF   <= 1'b1;
               BUSY <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed FIPS-197 key-schedule checks for aes_key_expander.
module tb_aes_key_expander;

   logic         CLK = 1'b0;
   logic         CLR, START, ENC_DEC;
   logic [255:0] KEY;
   logic [1:0]   KL;
   logic [3:0]   R;
   logic         KF, BUSY, KL_ERR;
   logic [127:0] RK;

   int total = 0;
   int bad   = 0;
   int n;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   aes_key_expander #(.MAXW(60)) dut (
      .CLK(CLK), .CLR(CLR), .START(START), .KEY(KEY), .KL(KL), .ENC_DEC(ENC_DEC),
      .R(R), .KF(KF), .BUSY(BUSY), .KL_ERR(KL_ERR), .RK(RK)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic do_start(input logic [255:0] k, input logic [1:0] l);
      @(negedge CLK);
      KEY   = k;
      KL    = l;
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   // Counts rising edges after the START edge until KF is seen; optionally
   // injects a stray START with a junk key on edge pulse_at.
   task automatic wait_kf(input int pulse_at, output int cnt);
      cnt = 0;
      while (cnt < 200) begin
         @(posedge CLK);
         #1;
         cnt++;
         if (cnt == pulse_at) begin
            START = 1'b1;
            KEY   = '1;
            KL    = 2'd2;
         end else begin
            START = 1'b0;
         end
         if (KF) break;
      end
      START = 1'b0;
   endtask

   task automatic read_rk(input logic ed, input logic [3:0] rr, output logic [127:0] v);
      @(negedge CLK);
      ENC_DEC = ed;
      R       = rr;
      @(negedge CLK);
      v = RK;
   endtask

   logic [127:0] v;

   initial begin
      CLR = 1'b0; START = 1'b0; KEY = '0; KL = 2'd0; ENC_DEC = 1'b1; R = 4'd0;
      repeat (3) @(negedge CLK);
      chk("rst_kf",     128'(KF),     128'd0);
      chk("rst_busy",   128'(BUSY),   128'd0);
      chk("rst_klerr",  128'(KL_ERR), 128'd0);
      chk("rst_rk",     RK,           128'd0);
      CLR = 1'b1;

      // AES-128 encrypt order
      do_start(K128, 2'd0);
      chk("a1_busy", 128'(BUSY), 128'd1);
      chk("a1_kf_lo", 128'(KF), 128'd0);
      wait_kf(-1, n);
      chk("a1_cycles", 128'(n), 128'd40);
      chk("a1_busy_done", 128'(BUSY), 128'd0);
      read_rk(1'b1, 4'd0, v);  chk("a1_r0",  v, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      read_rk(1'b1, 4'd1, v);  chk("a1_r1",  v, 128'ha0fafe1788542cb123a339392a6c7605);
      read_rk(1'b1, 4'd10, v); chk("a1_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      read_rk(1'b1, 4'd11, v); chk("a1_r11", v, 128'd0);

      // AES-128 decrypt order
      read_rk(1'b0, 4'd0, v);  chk("dec_r0",  v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      read_rk(1'b0, 4'd9, v);  chk("dec_r9",  v, 128'ha0fafe1788542cb123a339392a6c7605);
      read_rk(1'b0, 4'd10, v); chk("dec_r10", v, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      read_rk(1'b0, 4'd11, v); chk("dec_r11", v, 128'd0);

      // AES-192
      do_start(K192, 2'd1);
      wait_kf(-1, n);
      chk("a2_cycles", 128'(n), 128'd46);
      read_rk(1'b1, 4'd12, v); chk("a2_r12", v, 128'he98ba06f448c773c8ecc720401002202);
      read_rk(1'b1, 4'd0, v);  chk("a2_r0",  v, 128'h8e73b0f7da0e6452c810f32b809079e5);

      // AES-256
      do_start(K256, 2'd2);
      wait_kf(-1, n);
      chk("a3_cycles", 128'(n), 128'd52);
      read_rk(1'b1, 4'd14, v); chk("a3_r14", v, 128'hfe4890d1e6188d0b046df344706c631e);
      read_rk(1'b1, 4'd1, v);  chk("a3_r1",  v, 128'h1f352c073b6108d72d9810a30914dff4);
      read_rk(1'b0, 4'd14, v); chk("a3_dec_r14", v, 128'h603deb1015ca71be2b73aef0857d7781);

      // Reset in the middle of an AES-128 expansion
      ENC_DEC = 1'b1; R = 4'd10;
      do_start(K128, 2'd0);
      repeat (19) @(posedge CLK);
      @(negedge CLK);
      chk("mid_busy_pre", 128'(BUSY), 128'd1);
      CLR = 1'b0;
      @(negedge CLK);
      chk("mid_kf",   128'(KF),   128'd0);
      chk("mid_busy", 128'(BUSY), 128'd0);
      chk("mid_rk",   RK,         128'd0);
      CLR = 1'b1;
      do_start(K128, 2'd0);
      wait_kf(-1, n);
      chk("mid_cycles", 128'(n), 128'd40);
      read_rk(1'b1, 4'd10, v); chk("mid_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Illegal key length, then a legal run with a stray START mid-expansion
      do_start(K256, 2'd3);
      chk("bad_klerr", 128'(KL_ERR), 128'd1);
      chk("bad_kf",    128'(KF),     128'd0);
      repeat (3) @(negedge CLK);
      chk("bad_idle_busy", 128'(BUSY), 128'd0);
      chk("bad_idle_rk",   RK,         128'd0);
      do_start(K128, 2'd0);
      chk("clr_klerr", 128'(KL_ERR), 128'd0);
      chk("clr_busy",  128'(BUSY),   128'd1);
      wait_kf(10, n);
      chk("stray_cycles", 128'(n), 128'd40);
      read_rk(1'b1, 4'd1, v);  chk("stray_r1",  v, 128'ha0fafe1788542cb123a339392a6c7605);
      read_rk(1'b1, 4'd10, v); chk("stray_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
